asm_operand_encoder: RTL and testbench
======================================

// Module: asm_operand_encoder
// PURPOSE
// - Producer side of the ASM multiplier interface: takes operand pair (A,B), precomputes alphabet multiples
//   I1/I3/I5/I7 of B and encodes each 4-bit nibble of A into SEL/SL codes for the ASM multiplication unit.
// - Sequential: one shared adder for alphabets, one nibble encoded per cycle; valid/ready on both sides.
// PARAMETERS
// - WIDTH             32            operand width, multiple of 4
// - NIBBLE_WIDTH      4             nibble size (fixed)
// - LOG2_NIBBLE_WIDTH 2             width of one SEL/SL code
// - NIBBLES           WIDTH/4       nibbles per operand
// PORTS
// - clk        in   1                      single clock, rising edge
// - rst        in   1                      asynchronous, active-high reset
// - in_valid   in   1                      A/B valid
// - in_ready   out  1                      encoder can accept A/B
// - A          in   WIDTH                  operand to encode into SEL/SL (unsigned)
// - B          in   WIDTH                  operand to build alphabets from (unsigned)
// - out_valid  out  1                      I*/SEL_out/SL_out/A_out valid
// - out_ready  in   1                      consumer takes outputs
// - A_out      out  WIDTH                  registered copy of A (feeds Zero_Mux nibble inputs)
// - I1_wire,I3_wire,I5_wire,I7_wire out WIDTH+3 each   B, 3B, 5B, 7B, zero-extended
// - SEL_out    out  LOG2_NIBBLE_WIDTH*NIBBLES  nibble i at [2i+1:2i]; 0=I1 1=I3 2=I5 3=I7
// - SL_out     out  LOG2_NIBBLE_WIDTH*NIBBLES  nibble i left-shift 0..3, same packing
// BEHAVIOUR
// - Reset: state=IDLE, in_ready=1, out_valid=0, all data outputs 0, counter 0.
// - FSM IDLE: in_ready=1; in_valid&&in_ready captures A,B -> CALC, cnt=0.
// - CALC (in_ready=0): each cycle cnt increments; shared adder: cnt0 I3=B+(B<<1), cnt1 I5=B+(B<<2),
//   cnt2 I7=(B<<3)-B; I1=B at capture. Nibble cnt (cnt<NIBBLES) encoded into slot cnt.
//   Leave CALC when cnt==max(NIBBLES,3)-1 -> DONE. Latency accept->out_valid = max(NIBBLES,3)+1 cycles.
// - DONE: out_valid=1, outputs stable; out_valid&&out_ready -> IDLE (in_ready high next cycle). No
//   back-to-back accept in DONE; throughput one operand per max(NIBBLES,3)+2 cycles.
// - Nibble encoding n -> (SEL,SL), value = alphabet<<SL; nearest representable, ties round down:
//   0->(0,0) (zeroed downstream by nibble==0), 1->(0,0) 2->(0,1) 3->(1,0) 4->(0,2) 5->(2,0) 6->(1,1)
//   7->(3,0) 8->(0,3) 9->(0,3)~8 10->(2,1) 11->(2,1)~10 12->(1,2) 13->(1,2)~12 14->(3,1) 15->(3,1)~14.
// - Arithmetic unsigned; WIDTH+3 bits hold 7B with no overflow; subtraction never underflows.
// - in_valid ignored outside IDLE; out_ready ignored outside DONE; inputs sampled only on accept.
// - Reset asserted mid-CALC or DONE: immediate return to reset values, pending result discarded.
// CONFIGURATION
// - ASM_APPROX_FLAG_EN defined: extra output approx_flag (1 bit), valid with out_valid; 1 iff any nibble
//   of A in {9,11,13,15}; cleared by reset and on accept. Undefined: port absent, encoding identical.
// TESTING
// - Reset mid-CALC (WIDTH=32) -> next cycle out_valid=0, in_ready=1, all outputs 0; fresh op completes.
// - WIDTH=32, A=32'h7654_3210, B=5, out_ready=1 -> out_valid at cycle 9; I1=5 I3=15 I5=25 I7=35;
//   exact product via ASM unit = 0x7654_3210*5.
// - A=32'hFDB9_FDB9, B=1 -> all nibbles approximated (15->14,13->12,11->10,9->8); approx_flag=1 if enabled.
// - out_ready=0 for 20 cycles after out_valid -> outputs and out_valid held, in_ready=0; in_valid pulses
//   ignored; out_ready=1 -> IDLE, in_ready=1 next cycle.
// - B=32'hFFFF_FFFF -> I7=35'h6_FFFF_FFF9, I5=35'h4_FFFF_FFFB, I3=35'h2_FFFF_FFFD, no truncation.
// - WIDTH=8 (NIBBLES=2): latency governed by 3 alphabet cycles -> out_valid 4 cycles after accept.

Source files
------------

// File: rtl/asm_operand_encoder_if.sv
// Handshake and data bundle between the ASM operand encoder (slave) and its driver/consumer (master).
// With ASM_APPROX_FLAG_EN defined, the bundle also carries approx_flag.
interface asm_operand_encoder_if #(
    parameter int WIDTH = 32
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int CODE_W  = 2 * NIBBLES;

    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  A;
    logic [WIDTH-1:0]  B;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  A_out;
    logic [WIDTH+2:0]  I1_wire;
    logic [WIDTH+2:0]  I3_wire;
    logic [WIDTH+2:0]  I5_wire;
    logic [WIDTH+2:0]  I7_wire;
    logic [CODE_W-1:0] SEL_out;
    logic [CODE_W-1:0] SL_out;
`ifdef ASM_APPROX_FLAG_EN
    logic              approx_flag;
`endif

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, A_out, I1_wire, I3_wire, I5_wire, I7_wire, SEL_out, SL_out
`ifdef ASM_APPROX_FLAG_EN
        , input approx_flag
`endif
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, A_out, I1_wire, I3_wire, I5_wire, I7_wire, SEL_out, SL_out
`ifdef ASM_APPROX_FLAG_EN
        , output approx_flag
`endif
    );
endinterface

// File: rtl/asm_operand_encoder.sv
// ASM operand encoder: builds B/3B/5B/7B with one shared adder and encodes A one nibble per cycle
// into SEL/SL codes. Optional approx_flag output is enabled by defining ASM_APPROX_FLAG_EN.
module asm_operand_encoder #(
    parameter int WIDTH             = 32,
    parameter int NIBBLE_WIDTH      = 4,
    parameter int LOG2_NIBBLE_WIDTH = 2
) (
    input logic                  clk,
    input logic                  rst,
    asm_operand_encoder_if.slave bus
);
    localparam int NIBBLES = WIDTH / NIBBLE_WIDTH;
    localparam int MAXC    = (NIBBLES > 3) ? NIBBLES : 3;
    localparam int CNT_W   = $clog2(MAXC);
    localparam int XW      = WIDTH + 3;
    localparam int CODE_W  = LOG2_NIBBLE_WIDTH * NIBBLES;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            next_state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic [XW-1:0]     i1_r;
    logic [XW-1:0]     i3_r;
    logic [XW-1:0]     i5_r;
    logic [XW-1:0]     i7_r;
    logic [CODE_W-1:0] sel_r;
    logic [CODE_W-1:0] sl_r;
    logic              approx_r;
    logic              in_ready_s;
    logic              out_valid_s;
    logic              last_s;
    logic              accept_s;
    logic [XW-1:0]     b_ext_s;
    logic [XW-1:0]     add_a_s;
    logic [XW-1:0]     add_b_s;
    logic              sub_s;
    logic [XW-1:0]     sum_s;
    logic [3:0]        cur_nib_s;
    logic              nib_hit_s;
    logic [3:0]        enc_s;

    // Nearest alphabet<<shift for a nibble, ties rounding down; returns {sel, sl}.
    function automatic logic [3:0] encode_nibble(input logic [3:0] n);
        logic [3:0] code;
        case (n)
            4'd0:    code = 4'b00_00;
            4'd1:    code = 4'b00_00;
            4'd2:    code = 4'b00_01;
            4'd3:    code = 4'b01_00;
            4'd4:    code = 4'b00_10;
            4'd5:    code = 4'b10_00;
            4'd6:    code = 4'b01_01;
            4'd7:    code = 4'b11_00;
            4'd8:    code = 4'b00_11;
            4'd9:    code = 4'b00_11;
            4'd10:   code = 4'b10_01;
            4'd11:   code = 4'b10_01;
            4'd12:   code = 4'b01_10;
            4'd13:   code = 4'b01_10;
            4'd14:   code = 4'b11_01;
            4'd15:   code = 4'b11_01;
            default: code = 4'b00_00;
        endcase
        return code;
    endfunction

    assign last_s   = (cnt_r == CNT_W'(MAXC - 1));
    assign accept_s = (state_r == IDLE) && bus.in_valid;
    assign b_ext_s  = {3'b000, b_r};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE:    next_state_s = bus.in_valid ? CALC : IDLE;
            CALC:    next_state_s = last_s ? DONE : CALC;
            DONE:    next_state_s = bus.out_ready ? IDLE : DONE;
            default: next_state_s = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        case (state_r)
            IDLE:    in_ready_s  = 1'b1;
            DONE:    out_valid_s = 1'b1;
            default: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // Shared adder: 3B and 5B are additions, 7B is 8B minus B.
    always_comb begin
        add_a_s = b_ext_s;
        add_b_s = b_ext_s << 1;
        sub_s   = 1'b0;
        case (cnt_r)
            CNT_W'(0): add_b_s = b_ext_s << 1;
            CNT_W'(1): add_b_s = b_ext_s << 2;
            CNT_W'(2): begin
                add_a_s = b_ext_s << 3;
                add_b_s = b_ext_s;
                sub_s   = 1'b1;
            end
            default:   add_b_s = b_ext_s << 1;
        endcase
        sum_s = sub_s ? (add_a_s - add_b_s) : (add_a_s + add_b_s);
    end

    // Select the nibble addressed by the counter; cycles beyond the last nibble encode nothing.
    always_comb begin
        cur_nib_s = 4'h0;
        nib_hit_s = 1'b0;
        for (int i = 0; i < NIBBLES; i++) begin
            cur_nib_s = (cnt_r == CNT_W'(i)) ? a_r[NIBBLE_WIDTH*i +: NIBBLE_WIDTH] : cur_nib_s;
            nib_hit_s = nib_hit_s | (cnt_r == CNT_W'(i));
        end
        enc_s = encode_nibble(cur_nib_s);
    end

    // Operand capture, alphabet accumulation and SEL/SL slot writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r    <= '0;
            a_r      <= '0;
            b_r      <= '0;
            i1_r     <= '0;
            i3_r     <= '0;
            i5_r     <= '0;
            i7_r     <= '0;
            sel_r    <= '0;
            sl_r     <= '0;
            approx_r <= 1'b0;
        end else if (accept_s) begin
            cnt_r    <= '0;
            a_r      <= bus.A;
            b_r      <= bus.B;
            i1_r     <= {3'b000, bus.B};
            i3_r     <= '0;
            i5_r     <= '0;
            i7_r     <= '0;
            sel_r    <= '0;
            sl_r     <= '0;
            approx_r <= 1'b0;
        end else if (state_r == CALC) begin
            cnt_r <= last_s ? cnt_r : (cnt_r + CNT_W'(1));
            case (cnt_r)
                CNT_W'(0): i3_r <= sum_s;
                CNT_W'(1): i5_r <= sum_s;
                CNT_W'(2): i7_r <= sum_s;
                default:   i7_r <= i7_r;
            endcase
            for (int i = 0; i < NIBBLES; i++) begin
                if (cnt_r == CNT_W'(i)) begin
                    sel_r[LOG2_NIBBLE_WIDTH*i +: LOG2_NIBBLE_WIDTH] <= enc_s[3:2];
                    sl_r[LOG2_NIBBLE_WIDTH*i +: LOG2_NIBBLE_WIDTH]  <= enc_s[1:0];
                end
            end
            // Odd nibbles of 9 and above are the ones that cannot be represented exactly.
            if (nib_hit_s && cur_nib_s[3] && cur_nib_s[0]) begin
                approx_r <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.A_out     = a_r;
    assign bus.I1_wire   = i1_r;
    assign bus.I3_wire   = i3_r;
    assign bus.I5_wire   = i5_r;
    assign bus.I7_wire   = i7_r;
    assign bus.SEL_out   = sel_r;
    assign bus.SL_out    = sl_r;
`ifdef ASM_APPROX_FLAG_EN
    assign bus.approx_flag = approx_r;
`else
    logic unused_approx_s;
    assign unused_approx_s = approx_r;
`endif

endmodule

// File: tb/tb_asm_operand_encoder.sv
// Directed scoreboard bench for asm_operand_encoder at WIDTH=32 and WIDTH=8.
module tb_asm_operand_encoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    asm_operand_encoder_if #(.WIDTH(32)) bus32 ();
    asm_operand_encoder_if #(.WIDTH(8))  bus8 ();

    asm_operand_encoder #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
    asm_operand_encoder #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));

    typedef struct {
        logic [31:0] a;
        logic [34:0] i1, i3, i5, i7;
        logic [15:0] sel, sl;
        logic        apx;
    } exp_t;

    exp_t sb[$];
    int   vecs = 0;
    int   errs = 0;

    logic [1:0] sel_tab [16] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd3,
                                 2'd0, 2'd0, 2'd2, 2'd2, 2'd1, 2'd1, 2'd3, 2'd3};
    logic [1:0] sl_tab  [16] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0,
                                 2'd3, 2'd3, 2'd1, 2'd1, 2'd2, 2'd2, 2'd1, 2'd1};

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int nibs);
        exp_t       m;
        logic [3:0] nib;
        m.a   = a;
        m.i1  = {3'b000, b};
        m.i3  = 35'(b) * 35'd3;
        m.i5  = 35'(b) * 35'd5;
        m.i7  = 35'(b) * 35'd7;
        m.sel = 16'h0;
        m.sl  = 16'h0;
        m.apx = 1'b0;
        for (int i = 0; i < nibs; i++) begin
            nib = a[4*i +: 4];
            m.sel[2*i +: 2] = sel_tab[nib];
            m.sl[2*i +: 2]  = sl_tab[nib];
            if (nib == 4'd9 || nib == 4'd11 || nib == 4'd13 || nib == 4'd15) m.apx = 1'b1;
        end
        return m;
    endfunction

    // Product as the downstream ASM unit would form it from the encoder outputs.
    function automatic logic [63:0] recon(input logic [31:0] a, input logic [34:0] i1, i3, i5, i7,
                                          input logic [15:0] sel, sl, input int nibs);
        logic [63:0] acc;
        logic [34:0] alph;
        acc = 64'h0;
        for (int i = 0; i < nibs; i++) begin
            case (sel[2*i +: 2])
                2'd0:    alph = i1;
                2'd1:    alph = i3;
                2'd2:    alph = i5;
                default: alph = i7;
            endcase
            if (a[4*i +: 4] != 4'h0) acc = acc + ((64'(alph) << sl[2*i +: 2]) << (4 * i));
        end
        return acc;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vecs++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_vals(input string tag, input logic [31:0] a, input logic [34:0] i1, i3, i5, i7,
                              input logic [15:0] sel, sl, input logic apx);
        exp_t e;
        chk({tag, "_sb_size"}, 64'(sb.size()), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_A_out"}, 64'(a), 64'(e.a));
            chk({tag, "_I1"}, 64'(i1), 64'(e.i1));
            chk({tag, "_I3"}, 64'(i3), 64'(e.i3));
            chk({tag, "_I5"}, 64'(i5), 64'(e.i5));
            chk({tag, "_I7"}, 64'(i7), 64'(e.i7));
            chk({tag, "_SEL"}, 64'(sel), 64'(e.sel));
            chk({tag, "_SL"}, 64'(sl), 64'(e.sl));
`ifdef ASM_APPROX_FLAG_EN
            chk({tag, "_approx"}, 64'(apx), 64'(e.apx));
`else
            if (apx !== 1'b0) chk({tag, "_approx_tie"}, 64'(apx), 64'd0);
`endif
        end
    endtask

    task automatic check_out32(input string tag);
        logic apx;
`ifdef ASM_APPROX_FLAG_EN
        apx = bus32.approx_flag;
`else
        apx = 1'b0;
`endif
        check_vals(tag, bus32.A_out, bus32.I1_wire, bus32.I3_wire, bus32.I5_wire, bus32.I7_wire,
                   bus32.SEL_out, bus32.SL_out, apx);
    endtask

    // Called at a negedge with the encoder idle; returns one negedge after the accepting edge.
    task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic push);
        bus32.A        = a;
        bus32.B        = b;
        bus32.in_valid = 1'b1;
        if (push) sb.push_back(model(a, b, 8));
        @(negedge clk);
        bus32.in_valid = 1'b0;
    endtask

    task automatic wait32(input string tag, input int exp_lat);
        int cyc;
        cyc = 1;
        while (!bus32.out_valid && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    endtask

    task automatic back_to_idle32(input string tag);
        @(negedge clk);
        chk({tag, "_idle_in_ready"}, 64'(bus32.in_ready), 64'd1);
        chk({tag, "_idle_out_valid"}, 64'(bus32.out_valid), 64'd0);
    endtask

    initial begin
        logic [15:0] held_sel;
        logic [34:0] held_i7;
        logic        apx8;
        int          cyc;

        bus32.in_valid = 1'b0; bus32.A = 32'h0; bus32.B = 32'h0; bus32.out_ready = 1'b1;
        bus8.in_valid  = 1'b0; bus8.A  = 8'h0;  bus8.B  = 8'h0;  bus8.out_ready  = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(bus32.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus32.out_valid), 64'd0);
        chk("rst_A_out", 64'(bus32.A_out), 64'd0);
        chk("rst_I7", 64'(bus32.I7_wire), 64'd0);
        chk("rst_SEL", 64'(bus32.SEL_out), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Exact encoding of every small nibble, B=5.
        send32(32'h7654_3210, 32'd5, 1'b1);
        chk("t1_busy_in_ready", 64'(bus32.in_ready), 64'd0);
        wait32("t1", 9);
        chk("t1_I3_const", 64'(bus32.I3_wire), 64'd15);
        chk("t1_I7_const", 64'(bus32.I7_wire), 64'd35);
        chk("t1_product", recon(bus32.A_out, bus32.I1_wire, bus32.I3_wire, bus32.I5_wire, bus32.I7_wire,
                                bus32.SEL_out, bus32.SL_out, 8), 64'h7654_3210 * 64'd5);
        check_out32("t1");
        back_to_idle32("t1");

        // Every nibble approximated downward.
        send32(32'hFDB9_FDB9, 32'd1, 1'b1);
        wait32("t2", 9);
        chk("t2_product", recon(bus32.A_out, bus32.I1_wire, bus32.I3_wire, bus32.I5_wire, bus32.I7_wire,
                                bus32.SEL_out, bus32.SL_out, 8), 64'hECA8_ECA8);
        check_out32("t2");
        back_to_idle32("t2");

        // Consumer stall: result held, in_valid pulses ignored.
        bus32.out_ready = 1'b0;
        send32(32'h0F1E_2D3C, 32'h0000_1234, 1'b1);
        wait32("t3", 9);
        check_out32("t3");
        held_sel = 16'(bus32.SEL_out);
        held_i7  = bus32.I7_wire;
        for (int k = 0; k < 20; k++) begin
            bus32.A        = 32'hA5A5_0000 + 32'(k);
            bus32.B        = 32'h0000_0777;
            bus32.in_valid = (k % 2) == 0;
            @(negedge clk);
            chk("t3_hold_out_valid", 64'(bus32.out_valid), 64'd1);
            chk("t3_hold_in_ready", 64'(bus32.in_ready), 64'd0);
            chk("t3_hold_SEL", 64'(bus32.SEL_out), 64'(held_sel));
            chk("t3_hold_I7", 64'(bus32.I7_wire), 64'(held_i7));
        end
        bus32.in_valid  = 1'b0;
        bus32.out_ready = 1'b1;
        back_to_idle32("t3");

        // Full-scale B: alphabets need all three extra bits.
        send32(32'h8421_5A3C, 32'hFFFF_FFFF, 1'b1);
        wait32("t4", 9);
        chk("t4_I7_const", 64'(bus32.I7_wire), 64'h6_FFFF_FFF9);
        chk("t4_I5_const", 64'(bus32.I5_wire), 64'h4_FFFF_FFFB);
        chk("t4_I3_const", 64'(bus32.I3_wire), 64'h2_FFFF_FFFD);
        check_out32("t4");
        back_to_idle32("t4");

        // Reset in the middle of a calculation discards it.
        send32(32'h1111_1111, 32'd3, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t5_rst_out_valid", 64'(bus32.out_valid), 64'd0);
        chk("t5_rst_in_ready", 64'(bus32.in_ready), 64'd1);
        chk("t5_rst_A_out", 64'(bus32.A_out), 64'd0);
        chk("t5_rst_I3", 64'(bus32.I3_wire), 64'd0);
        chk("t5_rst_SEL", 64'(bus32.SEL_out), 64'd0);
        chk("t5_rst_SL", 64'(bus32.SL_out), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send32(32'h9ABC_DEF0, 32'h0000_0077, 1'b1);
        wait32("t5", 9);
        check_out32("t5");
        back_to_idle32("t5");

        // Narrow instance: latency set by the three alphabet cycles.
        bus8.A        = 8'hB7;
        bus8.B        = 8'h0D;
        bus8.in_valid = 1'b1;
        sb.push_back(model(32'h0000_00B7, 32'h0000_000D, 2));
        @(negedge clk);
        bus8.in_valid = 1'b0;
        cyc = 1;
        while (!bus8.out_valid && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        chk("t6_latency", 64'(cyc), 64'd4);
        chk("t6_product", recon(32'(bus8.A_out), 35'(bus8.I1_wire), 35'(bus8.I3_wire), 35'(bus8.I5_wire),
                                35'(bus8.I7_wire), 16'(bus8.SEL_out), 16'(bus8.SL_out), 2),
            64'h0A7 * 64'h0D);
`ifdef ASM_APPROX_FLAG_EN
        apx8 = bus8.approx_flag;
`else
        apx8 = 1'b0;
`endif
        check_vals("t6", 32'(bus8.A_out), 35'(bus8.I1_wire), 35'(bus8.I3_wire), 35'(bus8.I5_wire),
                   35'(bus8.I7_wire), 16'(bus8.SEL_out), 16'(bus8.SL_out), apx8);
        @(negedge clk);
        chk("t6_idle_in_ready", 64'(bus8.in_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
